// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared mode constants, state type and trace entry layout
package trace_pkg;

    localparam logic [1:0] MODE_CONT    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_TRIG    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } traceState_e;

    // Entry layout, MSB first: {pc, address, data, read, write}
    function automatic int entryWidth(input int addrW, input int dataW);
        return 2 * addrW + dataW + 2;
    endfunction

    function automatic int pcLsb(input int addrW, input int dataW);
        return addrW + dataW + 2;
    endfunction

    function automatic int addressLsb(input int addrW, input int dataW);
        return (addrW > 0) ? dataW + 2 : dataW + 2;
    endfunction

    function automatic int dataLsb(input int addrW, input int dataW);
        return (addrW + dataW > 0) ? 2 : 2;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace storage, one sync write port and one registered read port
module trace_ram #(
    parameter int WIDTH = 194,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    input  logic                     rdZero,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read-before-write: a same-edge write is visible only on the next read
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdData <= '0;
        end else begin
            rdData <= rdZero ? '0 : mem[rdAddr];
        end
    end

endmodule

// File: rtl/bus_trace_monitor.sv
// rtl/bus_trace_monitor.sv - bus trace buffer with continuous, one-shot and triggered capture
module bus_trace_monitor
    import trace_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int POST   = 8
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          sampleEn,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             data,
    input  logic                          read,
    input  logic                          write,
    input  logic [1:0]                    mode,
    input  logic [ADDR_W-1:0]             trigAddr,
    input  logic                          arm,
    input  logic                          stop,
    input  logic [$clog2(DEPTH)-1:0]      rdIndex,
    output logic [2*ADDR_W+DATA_W+1:0]    rdData,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          busy,
    output logic                          done,
    output logic                          triggered,
    output logic                          overflow
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entryWidth(ADDR_W, DATA_W);
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   LAST_FILL  = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0]   POST_LEFT  = (IDX_W+1)'(POST - 1);
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE    = IDX_W'(1);

    traceState_e        state;
    logic [1:0]         curMode;
    logic [IDX_W-1:0]   wrPtr;
    logic [IDX_W:0]     remain;

    logic               active;
    logic               wrEn;
    logic               hit;
    logic [ENTRY_W-1:0] entry;
    logic [IDX_W-1:0]   rdAddr;
    logic               rdZero;

    assign active = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign wrEn   = active && sampleEn;
    assign hit    = (address == trigAddr) && (read || write);
    assign entry  = {pc, address, data, read, write};

    // Once wrapped, the oldest entry sits at the write pointer
    assign rdAddr = (overflow ? wrPtr : '0) + rdIndex;
    assign rdZero = ({1'b0, rdIndex} >= count);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            curMode   <= MODE_CONT;
            wrPtr     <= '0;
            count     <= '0;
            remain    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_ONE;
                if (count == FULL_COUNT) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        wrPtr     <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        triggered <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        if (mode == MODE_TRIG) begin
                            curMode <= MODE_TRIG;
                            state   <= ST_ARMED;
                        end else begin
                            curMode <= (mode == MODE_CONT) ? MODE_CONT : MODE_ONESHOT;
                            state   <= ST_CAPTURE;
                        end
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (state == ST_ARMED && sampleEn && hit) begin
                        triggered <= 1'b1;
                        remain    <= POST_LEFT;
                    end
                    if (stop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (sampleEn) begin
                        if (state == ST_ARMED) begin
                            if (hit) begin
                                if (POST == 1) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= ST_CAPTURE;
                                end
                            end
                        end else if (curMode == MODE_ONESHOT) begin
                            if (count == LAST_FILL) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else if (curMode == MODE_TRIG) begin
                            remain <= remain - CNT_ONE;
                            if (remain == CNT_ONE) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    trace_ram #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_ram (
        .clock (clock),
        .resetN(resetN),
        .wrEn  (wrEn),
        .wrAddr(wrPtr),
        .wrData(entry),
        .rdAddr(rdAddr),
        .rdZero(rdZero),
        .rdData(rdData)
    );

endmodule

// File: doc/bus_trace_monitor.md
# bus_trace_monitor

Synthesizable on-chip trace buffer for the ProcessorDE0 system. It captures processor bus activity (PC, address, data, read, write) into a parametrised circular memory. Capture runs in one of three modes: continuous, one-shot or address-triggered with pre/post-trigger history. Captured entries are read back oldest-first through an indexed port, for on-board debug or framebuffer display of the bus history.

## Interface
- `ADDR_W`, 64, width of `pc` and `address`
- `DATA_W`, 64, width of `data`
- `DEPTH`, 16, number of trace entries; power of 2, ≥ 4
- `POST`, 8, entries captured from the trigger onward in mode 2, including the trigger entry; 1..DEPTH

- `clock`  in  1  system clock; all state changes on the rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `sampleEn`  in  1  one-cycle strobe per processor step; a sample is taken when high
- `pc`  in  ADDR_W  program counter
- `address`  in  ADDR_W  bus address
- `data`  in  DATA_W  bus data
- `read`, `write`  in  1 each  bus strobes
- `mode`  in  2  0 = continuous, 1 = one-shot, 2 = triggered, 3 = reserved (treated as 1); sampled on `arm`
- `trigAddr`  in  ADDR_W  trigger address for mode 2
- `arm`  in  1  start pulse
- `stop`  in  1  stop pulse
- `rdIndex`  in  log2(DEPTH)  logical index; 0 is the oldest entry
- `rdData`  out  2·ADDR_W+DATA_W+2  {pc, address, data, read, write}
- `count`  out  log2(DEPTH)+1  valid entries
- `busy`, `done`, `triggered`, `overflow`  out  1 each  status flags

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. `busy` is high in ARMED or CAPTURE.
- **arm** in IDLE or DONE:
  - Clears `count`, the write pointer, `overflow`, `triggered` and `done`, and latches `mode`.
  - Next state is ARMED for mode 2, otherwise CAPTURE.
  - `arm` is ignored in ARMED or CAPTURE.
- **Write rule:** in ARMED or CAPTURE, a `sampleEn` edge writes one entry at the write pointer and advances the pointer mod DEPTH. `count` increments and saturates at DEPTH.
- **Mode 0 (continuous):**
  - Once full, the oldest entry is overwritten and `overflow` is set.
  - Capture runs until `stop`.
- **Mode 1 (one-shot):** the write that makes `count`=DEPTH moves the block to DONE. No further writes.
- **Mode 2 (triggered):**
  - ARMED behaves like mode 0: it keeps pre-trigger history and may overflow.
  - Trigger condition: `sampleEn` && `address`==`trigAddr` && (`read`|`write`).
  - The trigger sample is written, `triggered` is set, and the state moves to CAPTURE with POST−1 writes remaining.
  - When the remaining count reaches 0 the block moves to DONE.
  - If POST=1, the trigger write goes directly to DONE.
- **stop** in ARMED or CAPTURE → DONE. If `sampleEn` is high in the same cycle, that sample is written first. `stop` is ignored in IDLE and DONE.
- **arm and stop together:**
  - In IDLE or DONE: `arm` wins.
  - In ARMED or CAPTURE: `stop` wins.
- **Readout** is allowed in any state:
  - Physical index = (`overflow` ? wrPtr : 0) + `rdIndex`, mod DEPTH.
  - If `rdIndex` ≥ `count`, `rdData` = 0.

## Timing
- Reset values: state IDLE, `count`=0, pointer 0, `busy`=`done`=`triggered`=`overflow`=0, `rdData`=0. Memory contents are not cleared.
- Capture latency: an entry is written, and `count`/flags update, on the edge where `sampleEn` is sampled high.
- `done` is high from the cycle after the final write or `stop`, until the next `arm`.
- `rdData` has a 1-cycle latency after `rdIndex` (registered read). It reflects writes completed on earlier edges.
- `resetN` asserted mid-capture aborts immediately and asynchronously. `rdData` is cleared.

## Structure
- Package `trace_pkg`:
  - mode constants (MODE_CONT, MODE_ONESHOT, MODE_TRIG)
  - state enum
  - entry field offset/width functions of ADDR_W and DATA_W
- Sub-module `trace_ram`: simple dual-port RAM with one synchronous write port and one synchronous read port, DEPTH × entry width. Its read output is `rdData`; the zeroing for `rdIndex` ≥ `count` and on reset is registered alongside it.
- FSM, pointers and counters live in the top module.

## Test plan
All scenarios use DEPTH=16 and POST=8. Sample i drives `address`=i·8, `pc`=0x1000+i·4, `read`=1.

1. Hold `resetN` low, then release → IDLE, `count`=0, all flags 0, `rdData`=0. Assert reset again mid-capture → the same values immediately.
2. Mode 1, `arm`, 20 samples → `done` after the 16th sample, `count`=16, `overflow`=0. `rdIndex` 0 → address 0x0; `rdIndex` 15 → 0x78. Samples 17–20 are not stored.
3. Mode 0, `arm`, 20 samples, then `stop` → `count`=16, `overflow`=1. `rdIndex` 0 → 0x20; `rdIndex` 15 → 0x98.
4. Mode 2, `trigAddr`=0x100, 40 samples → `triggered` at i=32, `done` after i=39, `count`=16. `rdIndex` 0 → 0xC0; `rdIndex` 8 → 0x100; `rdIndex` 15 → 0x138.
5. Mode 2, address 0x100 with `read`=`write`=0 → no trigger, state stays ARMED. Then `stop` and `sampleEn` in the same cycle → that sample is stored, `done`=1, `triggered`=0.
6. Mode 0, 3 samples, `stop`, then read `rdIndex` 5 → `rdData`=0. Pulse `arm` while in CAPTURE → ignored, and `count` is not cleared.
